data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port DataMemory (address / writeData / MemRead / MemWrite / readData).
- Shares the memory between requester 0 (CPU load/store path) and requester 1 (loader/debug port).
- Uses a req/ack handshake per requester and round-robin grant.
- Drives exactly one memory access at a time, then returns read data and ack to the winner.

Parameters:
- ADDR_W, 32, width of address buses.
- DATA_W, 32, width of data buses.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- m0_req  input  1  requester 0 access request; held until ack.
- m0_we  input  1  requester 0: 1 = write, 0 = read.
- m0_addr  input  ADDR_W  requester 0 address.
- m0_wdata  input  DATA_W  requester 0 write data.
- m0_ack  output  1  one-cycle completion pulse to requester 0.
- m0_rdata  output  DATA_W  read data for requester 0, valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_* for requester 1.
- mem_address  output  ADDR_W  to DataMemory address.
- mem_writeData  output  DATA_W  to DataMemory writeData.
- mem_MemRead  output  1  to DataMemory MemRead.
- mem_MemWrite  output  1  to DataMemory MemWrite.
- mem_readData  input  DATA_W  from DataMemory readData (combinational read).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - All ack, MemRead and MemWrite = 0.
  - mem_address, mem_writeData, m0_rdata and m1_rdata = 0.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered or decoded from state plus latched registers. No combinational path from m*_req to mem_*.
- IDLE:
  - Neither req: stay.
  - One req: grant it.
  - Both: grant the requester != last_grant.
  - On grant: latch addr, wdata, we and the winner id. Next state is ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_address/mem_writeData = latched values.
  - mem_MemWrite = we, mem_MemRead = !we.
  - On the closing edge: capture mem_readData into the winner's rdata register (reads only; the write leaves rdata unchanged). Next state is DONE.
- DONE (exactly 1 cycle):
  - Winner's ack=1; MemRead=MemWrite=0.
  - last_grant updates to the winner. Next state is IDLE.
- Latency:
  - Req sampled at edge E0 → ACCESS in cycle E0..E1 → ack high in cycle E1..E2.
  - Minimum 3 cycles between successive grants.
- Handshake rules:
  - Requester keeps req/we/addr/wdata stable until it sees ack.
  - Payload changes after the grant edge are ignored (latched).
  - A req still high in the cycle after ack is treated as a new request.
- Loser requester:
  - Its req stays pending with no ack.
  - It is guaranteed the next grant (round-robin): worst-case wait is one access (3 cycles).
- m0_ack and m1_ack are never high simultaneously.
- rdata registers hold their value until overwritten by that requester's next read.
- Reset mid-operation:
  - rst during ACCESS drops mem_MemWrite/MemRead immediately (async), so no write commits.
  - rst during DONE suppresses ack. The requester must reissue.
- Req deasserted while pending (protocol violation): the access still completes if already granted; otherwise it is never granted.

Optional Feature:
- Macro DATA_MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins a tie; last_grant is unused (may be optimized away); requester 1 can starve.
- Undefined: round-robin as described above.

Decomposition:
- Package data_mem_arb_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2.
  - Requester id constants REQ_M0=1'b0, REQ_M1=1'b1.
- One natural sub-module, arb_rr_select:
  - Combinational 2-way picker: inputs req[1:0] and last_grant; outputs grant_valid and grant_id.
  - Honours DATA_MEM_ARB_FIXED_PRIO_EN.

Test Plan:
- Single read: memory preloaded word@4=0xDEADBEEF; m0_req, m0_we=0, m0_addr=4 → MemRead=1 for one cycle with mem_address=4; m0_ack pulses 2 cycles after the req edge with m0_rdata=0xDEADBEEF.
- Write then read-back: m1 writes 23 to address 1 (MemWrite=1 exactly one cycle, mem_writeData=23), then m1 reads address 1 → m1_rdata=23.
- Contention: m0 and m1 requesting continuously from reset → grants alternate m0, m1, m0, m1; acks every 3 cycles; never both acks high.
- Fixed priority (macro defined): both requesting continuously → only m0 acked; m1 is granted only after m0 drops req.
- Async reset during ACCESS of a write of 0x55 to address 8: assert rst mid-cycle → MemWrite falls immediately, location 8 unchanged, no ack, FSM in IDLE after release.
- Payload change after grant: m0 changes m0_addr from 4 to 12 in the ACCESS cycle → mem_address stays 4, returned data is from address 4.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared encodings for the DataMemory arbiter slice.
// Optional feature macro: DATA_MEM_ARB_FIXED_PRIO_EN (fixed priority, requester 0 wins ties).
package data_mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    DONE   = ST_DONE
  } arbState_t;

endpackage

// File: rtl/arb_rr_select.sv
// Two-way request picker: round-robin on ties, or fixed priority to
// requester 0 when DATA_MEM_ARB_FIXED_PRIO_EN is defined.
module arb_rr_select
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  logic unusedLastGrant;
  assign unusedLastGrant = last_grant;

  // Requester 0 always wins; requester 1 only when alone
  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_M0;
    if (!req[0] && req[1]) grant_id = REQ_M1;
  end
`else
  // On a tie the requester that did not win last time goes next
  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_M0;
    if (req == 2'b11)  grant_id = ~last_grant;
    else if (req[1])   grant_id = REQ_M1;
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer in front of the single-port DataMemory.
// One access at a time: IDLE (grant) -> ACCESS (strobe) -> DONE (ack).
// Optional feature macro: DATA_MEM_ARB_FIXED_PRIO_EN (see arb_rr_select).
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_readData
);

  arbState_t state;
  logic      lastGrant;
  logic      curId;
  logic      curWe;
  logic      selValid;
  logic      selId;

  arb_rr_select uSelect (
    .req         ({m1_req, m0_req}),
    .last_grant  (lastGrant),
    .grant_valid (selValid),
    .grant_id    (selId)
  );

  // Sequencer: latch the winner in IDLE, strobe memory for one cycle, then ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lastGrant     <= REQ_M1;
      curId         <= REQ_M0;
      curWe         <= 1'b0;
      m0_ack        <= 1'b0;
      m1_ack        <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
      mem_address   <= '0;
      mem_writeData <= '0;
      mem_MemRead   <= 1'b0;
      mem_MemWrite  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          if (selValid) begin
            curId         <= selId;
            curWe         <= (selId == REQ_M1) ? m1_we : m0_we;
            mem_address   <= (selId == REQ_M1) ? m1_addr : m0_addr;
            mem_writeData <= (selId == REQ_M1) ? m1_wdata : m0_wdata;
            mem_MemWrite  <= (selId == REQ_M1) ? m1_we : m0_we;
            mem_MemRead   <= (selId == REQ_M1) ? !m1_we : !m0_we;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          mem_MemRead  <= 1'b0;
          mem_MemWrite <= 1'b0;
          if (!curWe) begin
            if (curId == REQ_M1) m1_rdata <= mem_readData;
            else                 m0_rdata <= mem_readData;
          end
          m0_ack <= (curId == REQ_M0);
          m1_ack <= (curId == REQ_M1);
          state  <= DONE;
        end
        DONE: begin
          m0_ack    <= 1'b0;
          m1_ack    <= 1'b0;
          lastGrant <= curId;
          state     <= IDLE;
        end
        default: begin
          m0_ack       <= 1'b0;
          m1_ack       <= 1'b0;
          mem_MemRead  <= 1'b0;
          mem_MemWrite <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a small word-indexed memory model.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_MemRead, mem_MemWrite;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [31:0] rd;
  } expect_t;

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
  } vec_t;

  expect_t sb[$];
  expect_t popped;
  logic [31:0] mem [32];

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  // DataMemory model: combinational read, write on rising edge
  assign mem_readData = mem[mem_address[4:0]];
  always @(posedge clk) begin
    if (mem_MemWrite) mem[mem_address[4:0]] <= mem_writeData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack must match the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_ack && m1_ack) begin
        checks++; errors++;
        $display("FAIL bothAcks: m0_ack and m1_ack high together at %0t", $time);
      end else if (m0_ack || m1_ack) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpectedAck: got ack id %0d with nothing pending at %0t", m1_ack, $time);
        end else begin
          popped = sb.pop_front();
          check("ackId", {31'd0, m1_ack}, {31'd0, popped.id});
          check("ackRdata", m1_ack ? m1_rdata : m0_rdata, popped.rd);
        end
      end
    end
  end

  task automatic setReq(input logic id, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    if (id) begin m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
    else    begin m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
  endtask

  // One isolated access: grant edge, one ACCESS cycle, ack on the next edge
  task automatic runOne(input logic id, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] expRd, input bit chgAddr);
    int ackEdge;
    logic gotAck;
    @(posedge clk); #1;
    setReq(id, 1'b1, we, addr, wdata);
    sb.push_back('{id: id, rd: expRd});
    @(posedge clk); #1;
    check("accessRead", {31'd0, mem_MemRead}, {31'd0, !we});
    check("accessWrite", {31'd0, mem_MemWrite}, {31'd0, we});
    check("accessAddr", mem_address, addr);
    if (we) check("accessWdata", mem_writeData, wdata);
    if (chgAddr) setReq(id, 1'b1, we, 32'd12, wdata);
    gotAck = 1'b0;
    ackEdge = 0;
    for (int k = 1; k <= 6 && !gotAck; k++) begin
      @(posedge clk); #1;
      gotAck = id ? m1_ack : m0_ack;
      ackEdge = k;
      if (k == 1) begin
        check("strobeDropRd", {31'd0, mem_MemRead}, 32'd0);
        check("strobeDropWr", {31'd0, mem_MemWrite}, 32'd0);
      end
    end
    if (!gotAck) begin
      checks++; errors++;
      $display("FAIL ackTimeout: no ack for id %0d addr %h", id, addr);
    end else begin
      check("ackLatency", ackEdge, 32'd1);
    end
    setReq(id, 1'b0, 1'b0, '0, '0);
  endtask

  vec_t vecs[8];
  logic anyAck, gotM1;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[4]  = 32'hDEADBEEF;
    mem[8]  = 32'h12345678;
    mem[12] = 32'hCAFEF00D;

    vecs[0] = '{id: 1'b0, we: 1'b0, addr: 32'd4,  wdata: 32'd0,      expRd: 32'hDEADBEEF};
    vecs[1] = '{id: 1'b1, we: 1'b1, addr: 32'd1,  wdata: 32'd23,     expRd: 32'd0};
    vecs[2] = '{id: 1'b1, we: 1'b0, addr: 32'd1,  wdata: 32'd0,      expRd: 32'd23};
    vecs[3] = '{id: 1'b0, we: 1'b1, addr: 32'd5,  wdata: 32'hA5A5,   expRd: 32'hDEADBEEF};
    vecs[4] = '{id: 1'b0, we: 1'b0, addr: 32'd5,  wdata: 32'd0,      expRd: 32'hA5A5};
    vecs[5] = '{id: 1'b1, we: 1'b0, addr: 32'd12, wdata: 32'd0,      expRd: 32'hCAFEF00D};
    vecs[6] = '{id: 1'b1, we: 1'b1, addr: 32'd12, wdata: 32'h77,     expRd: 32'hCAFEF00D};
    vecs[7] = '{id: 1'b0, we: 1'b0, addr: 32'd12, wdata: 32'd0,      expRd: 32'h77};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rstAck0", {31'd0, m0_ack}, 32'd0);
    check("rstAck1", {31'd0, m1_ack}, 32'd0);
    check("rstMemRead", {31'd0, mem_MemRead}, 32'd0);
    check("rstMemWrite", {31'd0, mem_MemWrite}, 32'd0);
    check("rstAddr", mem_address, 32'd0);
    check("rstWdata", mem_writeData, 32'd0);
    check("rstRdata0", m0_rdata, 32'd0);
    check("rstRdata1", m1_rdata, 32'd0);
    rst = 1'b0;

    // Table of single accesses
    foreach (vecs[i]) runOne(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expRd, 1'b0);
    check("memWrite1", mem[1], 32'd23);
    check("memWrite12", mem[12], 32'h77);
    mem[12] = 32'hCAFEF00D;

    // Payload change after grant is ignored
    runOne(1'b0, 1'b0, 32'd4, 32'd0, 32'hDEADBEEF, 1'b1);
    repeat (2) @(posedge clk);

    // Async reset during ACCESS of a write
    @(posedge clk); #1;
    setReq(1'b0, 1'b1, 1'b1, 32'd8, 32'h55);
    @(posedge clk); #1;
    check("preRstWrite", {31'd0, mem_MemWrite}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstDropWrite", {31'd0, mem_MemWrite}, 32'd0);
    check("rstDropRead", {31'd0, mem_MemRead}, 32'd0);
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("noAckAfterRst", {31'd0, m0_ack}, 32'd0);
    end
    check("mem8Kept", mem[8], 32'h12345678);
    runOne(1'b0, 1'b0, 32'd8, 32'd0, 32'h12345678, 1'b0);

    // Contention from reset
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("sbEmptyPreContention", sb.size(), 32'd0);
    setReq(1'b0, 1'b1, 1'b0, 32'd4, 32'd0);
    setReq(1'b1, 1'b1, 1'b0, 32'd1, 32'd0);
    for (int n = 0; n < 4; n++) begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
      sb.push_back('{id: 1'b0, rd: 32'hDEADBEEF});
`else
      if (n % 2 == 0) sb.push_back('{id: 1'b0, rd: 32'hDEADBEEF});
      else            sb.push_back('{id: 1'b1, rd: 32'd23});
`endif
    end
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      anyAck = m0_ack | m1_ack;
      check("ackCadence", {31'd0, anyAck}, {31'd0, (i % 3 == 2)});
    end
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    sb.push_back('{id: 1'b1, rd: 32'd23});
    gotM1 = 1'b0;
    for (int k = 0; k < 6 && !gotM1; k++) begin
      @(posedge clk); #1;
      gotM1 = m1_ack;
    end
    check("m1AfterM0Drops", {31'd0, gotM1}, 32'd1);
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
`else
    gotM1 = 1'b0;
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
`endif
    repeat (4) @(posedge clk);
    #1;
    check("sbDrained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
